// File: rtl/fir_xifu_issue_q.sv
// fir_xifu_issue_q -- XIF issue/decode stage of the FIR XIFU.
//
// Decodes custom-opcode instructions (xfirlw, xfirsw, xfirdotp and optionally
// xfirdotpz), answers the XIF issue request and queues accepted instructions
// in a DEPTH-entry FIFO towards EX. A per-register busy scoreboard holds off
// issue while an instruction would read or write an XIFU register that an
// older, not yet written-back instruction is going to write.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   clear_i               synchronous flush of FIFO and scoreboard
//   issue_*               XIF issue request / response
//   ctrl_issue_o/ctrl_id_o pulse + id for every accepted instruction
//   ex_*                  FIFO head towards EX (all zero while empty)
//   wb_valid_i/wb_rd_i    EX write-back of an XIFU register (clears busy)
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high. issue_ready_o never depends on anything registered from the same
// cycle's transfer; ex_valid_o depends only on FIFO state, never on ex_ready_i.
module fir_xifu_issue_q #(
   parameter int         NREGS    = 32,
   parameter int         DEPTH    = 2,
   parameter int         ID_W     = 4,
   parameter logic [6:0] OPCODE   = 7'h0B,
   parameter bit         EN_DOTPZ = 1'b1,
   localparam int        REG_W    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             issue_valid_i,
   output logic             issue_ready_o,
   input  logic [31:0]      issue_instr_i,
   input  logic [31:0]      issue_rs0_i,
   input  logic [ID_W-1:0]  issue_id_i,
   output logic             issue_accept_o,
   output logic             issue_wb_o,
   output logic             issue_ls_o,
   output logic             ctrl_issue_o,
   output logic [ID_W-1:0]  ctrl_id_o,
   output logic             ex_valid_o,
   input  logic             ex_ready_i,
   output logic [1:0]       ex_op_o,
   output logic [31:0]      ex_base_o,
   output logic [31:0]      ex_offset_o,
   output logic [4:0]       ex_shift_o,
   output logic [REG_W-1:0] ex_rs1_o,
   output logic [REG_W-1:0] ex_rs2_o,
   output logic [REG_W-1:0] ex_rd_o,
   output logic [ID_W-1:0]  ex_id_o,
   input  logic             wb_valid_i,
   input  logic [REG_W-1:0] wb_rd_i
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [1:0] OP_LW    = 2'd0;
   localparam logic [1:0] OP_SW    = 2'd1;
   localparam logic [1:0] OP_DOTP  = 2'd2;
   localparam logic [1:0] OP_DOTPZ = 2'd3;

   typedef struct packed {
      logic [1:0]       op;
      logic [31:0]      base;
      logic [31:0]      offset;
      logic [4:0]       shift;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic [ID_W-1:0]  id;
   } entry_t;

   entry_t             mem_q [DEPTH];
   entry_t             mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [NREGS-1:0]   busy_q, busy_d;

   // Instruction fields
   logic [4:0]       rd_f, rs1_f, rs2_f;
   logic [2:0]       funct3;
   logic [REG_W-1:0] rd_idx, rs1_idx, rs2_idx;

   assign rd_f    = issue_instr_i[11:7];
   assign rs1_f   = issue_instr_i[19:15];
   assign rs2_f   = issue_instr_i[24:20];
   assign funct3  = issue_instr_i[14:12];
   assign rd_idx  = REG_W'(rd_f);
   assign rs1_idx = REG_W'(rs1_f);
   assign rs2_idx = REG_W'(rs2_f);

   function automatic logic reg_oob(input logic [4:0] f);
      return {27'd0, f} >= 32'(NREGS);
   endfunction

   // Decode results
   logic        dec_ok, dec_lsw;
   logic [1:0]  dec_op;
   logic [31:0] dec_offset;
   logic [4:0]  dec_shift;
   logic        uses_rs1, uses_rs2, uses_rd, writes_rd;
   logic        reg_bad, accept, hazard, full, push, pop;
   entry_t      new_entry, head;

   always_comb begin
      dec_ok     = 1'b0;
      dec_lsw    = 1'b0;
      dec_op     = OP_LW;
      dec_offset = 32'd0;
      dec_shift  = 5'd0;
      uses_rs1   = 1'b0;
      uses_rs2   = 1'b0;
      uses_rd    = 1'b0;
      writes_rd  = 1'b0;
      if (issue_instr_i[6:0] == OPCODE) begin
         unique case (funct3)
            3'b000: begin
               dec_ok     = 1'b1;
               dec_lsw    = 1'b1;
               dec_op     = OP_LW;
               dec_offset = {{20{issue_instr_i[31]}}, issue_instr_i[31:20]};
               writes_rd  = 1'b1;
            end
            3'b001: begin
               // rd field carries the store shift amount, not a register
               dec_ok     = 1'b1;
               dec_lsw    = 1'b1;
               dec_op     = OP_SW;
               dec_offset = {{25{issue_instr_i[31]}}, issue_instr_i[31:25]};
               dec_shift  = rd_f;
               uses_rs2   = 1'b1;
            end
            3'b010: begin
               dec_ok    = 1'b1;
               dec_op    = OP_DOTP;
               uses_rs1  = 1'b1;
               uses_rs2  = 1'b1;
               uses_rd   = 1'b1;
               writes_rd = 1'b1;
            end
            3'b011: begin
               dec_ok    = EN_DOTPZ;
               dec_op    = OP_DOTPZ;
               uses_rs1  = 1'b1;
               uses_rs2  = 1'b1;
               writes_rd = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign reg_bad = (uses_rs1 & reg_oob(rs1_f)) |
                    (uses_rs2 & reg_oob(rs2_f)) |
                    ((uses_rd | writes_rd) & reg_oob(rd_f));
   assign accept  = dec_ok & ~reg_bad;

   // Only meaningful when accept is high, where every used index is in range
   assign hazard  = (uses_rs1 & busy_q[rs1_idx]) |
                    (uses_rs2 & busy_q[rs2_idx]) |
                    ((uses_rd | writes_rd) & busy_q[rd_idx]);

   assign full    = (count_q == CNT_W'(DEPTH));

   // Unsupported instructions are answered immediately (accept=0) without
   // waiting for FIFO space or hazards.
   assign issue_ready_o  = issue_valid_i & ~clear_i & (~accept | (~full & ~hazard));
   assign issue_accept_o = issue_valid_i & accept;
   assign issue_wb_o     = issue_valid_i & accept & dec_lsw;
   assign issue_ls_o     = issue_valid_i & accept & dec_lsw;

   assign push         = issue_valid_i & issue_ready_o & accept;
   assign ctrl_issue_o = push;
   assign ctrl_id_o    = push ? issue_id_i : '0;

   always_comb begin
      new_entry        = '0;
      new_entry.op     = dec_op;
      new_entry.base   = issue_rs0_i;
      new_entry.offset = dec_offset;
      new_entry.shift  = dec_shift;
      new_entry.rs1    = rs1_idx;
      new_entry.rs2    = rs2_idx;
      new_entry.rd     = rd_idx;
      new_entry.id     = issue_id_i;
   end

   assign ex_valid_o = (count_q != '0);
   assign pop        = ex_valid_o & ex_ready_i;
   assign head       = ex_valid_o ? mem_q[rd_ptr_q] : '0;

   assign ex_op_o     = head.op;
   assign ex_base_o   = head.base;
   assign ex_offset_o = head.offset;
   assign ex_shift_o  = head.shift;
   assign ex_rs1_o    = head.rs1;
   assign ex_rs2_o    = head.rs2;
   assign ex_rd_o     = head.rd;
   assign ex_id_o     = head.id;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      busy_d   = busy_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         busy_d   = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         // Clear first so a same-cycle set of the same register wins
         if (wb_valid_i) begin
            busy_d[wb_rd_i] = 1'b0;
         end
         if (push & writes_rd) begin
            busy_d[rd_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         busy_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: tb/tb_fir_xifu_issue_q.sv
// Testbench for fir_xifu_issue_q: directed steps followed by a random phase,
// each cycle compared against a queue/array reference model of the issue stage.
// A second instance (NREGS=16, EN_DOTPZ=0) shares the issue inputs and is used
// only for decode-acceptance checks.
module tb_fir_xifu_issue_q;

   localparam int DEPTH = 2;
   localparam int EW    = 2 + 32 + 32 + 5 + 5 * 3 + 4;

   // Clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        clear, issue_valid, ex_ready, wb_valid;
   logic [31:0] issue_instr, issue_rs0;
   logic [3:0]  issue_id;
   logic [4:0]  wb_rd;

   logic        issue_ready, issue_accept, issue_wb, issue_ls, ctrl_issue, ex_valid;
   logic [3:0]  ctrl_id, ex_id;
   logic [1:0]  ex_op;
   logic [31:0] ex_base, ex_offset;
   logic [4:0]  ex_shift, ex_rs1, ex_rs2, ex_rd;

   logic        d2_ready, d2_accept, d2_wb, d2_ls, d2_ctrl_issue, d2_ex_valid;
   logic [3:0]  d2_ctrl_id, d2_ex_id, d2_ex_rs1, d2_ex_rs2, d2_ex_rd;
   logic [1:0]  d2_ex_op;
   logic [31:0] d2_ex_base, d2_ex_offset;
   logic [4:0]  d2_ex_shift;

   fir_xifu_issue_q #(.NREGS(32), .DEPTH(DEPTH), .ID_W(4), .OPCODE(7'h0B), .EN_DOTPZ(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear),
      .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
      .issue_instr_i(issue_instr), .issue_rs0_i(issue_rs0), .issue_id_i(issue_id),
      .issue_accept_o(issue_accept), .issue_wb_o(issue_wb), .issue_ls_o(issue_ls),
      .ctrl_issue_o(ctrl_issue), .ctrl_id_o(ctrl_id),
      .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .ex_op_o(ex_op),
      .ex_base_o(ex_base), .ex_offset_o(ex_offset), .ex_shift_o(ex_shift),
      .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd), .ex_id_o(ex_id),
      .wb_valid_i(wb_valid), .wb_rd_i(wb_rd)
   );

   fir_xifu_issue_q #(.NREGS(16), .DEPTH(DEPTH), .ID_W(4), .OPCODE(7'h0B), .EN_DOTPZ(1'b0)) dut2 (
      .clk_i(clk), .rst_i(rst), .clear_i(clear),
      .issue_valid_i(issue_valid), .issue_ready_o(d2_ready),
      .issue_instr_i(issue_instr), .issue_rs0_i(issue_rs0), .issue_id_i(issue_id),
      .issue_accept_o(d2_accept), .issue_wb_o(d2_wb), .issue_ls_o(d2_ls),
      .ctrl_issue_o(d2_ctrl_issue), .ctrl_id_o(d2_ctrl_id),
      .ex_valid_o(d2_ex_valid), .ex_ready_i(1'b1), .ex_op_o(d2_ex_op),
      .ex_base_o(d2_ex_base), .ex_offset_o(d2_ex_offset), .ex_shift_o(d2_ex_shift),
      .ex_rs1_o(d2_ex_rs1), .ex_rs2_o(d2_ex_rs2), .ex_rd_o(d2_ex_rd), .ex_id_o(d2_ex_id),
      .wb_valid_i(wb_valid), .wb_rd_i(wb_rd[3:0])
   );

   // Scoreboard / reference model
   int           checks = 0;
   int           errors = 0;
   logic [EW-1:0] exp_q[$];
   bit           busy_m [32];
   logic         s_ready, s_accept, s2_accept;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural decode straight from the instruction-set rules
   function automatic void mdl_decode(input logic [31:0] ins, input int nregs, input bit en_z,
                                      output bit acc, output bit lsw, output logic [1:0] op,
                                      output logic [31:0] off, output logic [4:0] sh,
                                      output bit r1, output bit r2, output bit rr, output bit w);
      acc = 0; lsw = 0; op = 0; off = 0; sh = 0; r1 = 0; r2 = 0; rr = 0; w = 0;
      if (ins[6:0] == 7'h0B) begin
         case (ins[14:12])
            3'd0: begin acc = 1; lsw = 1; op = 0; off = 32'($signed(ins[31:20])); w = 1; end
            3'd1: begin acc = 1; lsw = 1; op = 1; off = 32'($signed(ins[31:25])); sh = ins[11:7]; r2 = 1; end
            3'd2: begin acc = 1; op = 2; r1 = 1; r2 = 1; rr = 1; w = 1; end
            3'd3: begin acc = en_z; op = 3; r1 = 1; r2 = 1; w = 1; end
            default: ;
         endcase
      end
      if ((r1 && int'(ins[19:15]) >= nregs) || (r2 && int'(ins[24:20]) >= nregs) ||
          ((rr || w) && int'(ins[11:7]) >= nregs))
         acc = 0;
   endfunction

   function automatic logic [31:0] mk(input logic [6:0] hi, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
      return {hi, rs2, rs1, f3, rd, opc};
   endfunction

   // Driver: one clock cycle of stimulus, checked at the falling edge,
   // model advanced at the rising edge.
   task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] rs0, input logic [3:0] id,
                       input bit exr, input bit wbv, input logic [4:0] wbr, input bit clr);
      bit acc, lsw, r1, r2, rr, w, hz, e_acc, e_rdy, e_push;
      logic [1:0]  op;
      logic [31:0] off;
      logic [4:0]  sh;
      logic [EW-1:0] ent, head;
      issue_valid = v; issue_instr = ins; issue_rs0 = rs0; issue_id = id;
      ex_ready = exr; wb_valid = wbv; wb_rd = wbr; clear = clr;
      @(negedge clk);
      mdl_decode(ins, 32, 1'b1, acc, lsw, op, off, sh, r1, r2, rr, w);
      hz     = (r1 && busy_m[ins[19:15]]) || (r2 && busy_m[ins[24:20]]) || ((rr || w) && busy_m[ins[11:7]]);
      e_acc  = v && acc;
      e_rdy  = v && !clr && (!acc || (exp_q.size() < DEPTH && !hz));
      e_push = e_rdy && e_acc;
      ent    = {op, rs0, off, sh, ins[19:15], ins[24:20], ins[11:7], id};
      head   = (exp_q.size() != 0) ? exp_q[0] : '0;
      check("issue_ready", issue_ready, e_rdy);
      check("issue_accept", issue_accept, e_acc);
      check("issue_wb", issue_wb, e_acc && lsw);
      check("issue_ls", issue_ls, e_acc && lsw);
      check("ctrl_issue", ctrl_issue, e_push);
      check("ctrl_id", ctrl_id, e_push ? id : 4'd0);
      check("ex_valid", ex_valid, exp_q.size() != 0);
      check("ex_fields", {ex_op, ex_base, ex_offset, ex_shift, ex_rs1, ex_rs2, ex_rd, ex_id}, head);
      s_ready = issue_ready; s_accept = issue_accept; s2_accept = d2_accept;
      @(posedge clk);
      if (clr) begin
         exp_q.delete();
         foreach (busy_m[i]) busy_m[i] = 0;
      end else begin
         if (exp_q.size() != 0 && exr) void'(exp_q.pop_front());
         if (e_push) exp_q.push_back(ent);
         if (wbv) busy_m[wbr] = 0;
         if (e_push && w) busy_m[ins[11:7]] = 1;
      end
      #1;
   endtask

   task automatic idle(input bit exr, input bit wbv, input logic [4:0] wbr);
      step(1'b0, 32'd0, 32'd0, 4'd0, exr, wbv, wbr, 1'b0);
   endtask

   initial begin
      clear = 0; issue_valid = 0; issue_instr = 0; issue_rs0 = 0; issue_id = 0;
      ex_ready = 0; wb_valid = 0; wb_rd = 0;
      foreach (busy_m[i]) busy_m[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ex_valid", ex_valid, 1'b0);
      check("rst_ready", issue_ready, 1'b0);
      check("rst_ex_fields", {ex_op, ex_base, ex_offset, ex_id}, '0);
      @(negedge clk);
      rst = 0;
      @(posedge clk);
      #1;

      // LW x3, imm=-4, base 0x1000
      step(1, mk(7'h7F, 5'h1C, 5'd0, 3'b000, 5'd3, 7'h0B), 32'h1000, 4'd1, 0, 0, 0, 0);
      check("lw_accept", s_accept, 1'b1);
      check("lw_ready", s_ready, 1'b1);
      check("lw_ex_valid", ex_valid, 1'b1);
      check("lw_ex_op", ex_op, 2'd0);
      check("lw_ex_base", ex_base, 32'h1000);
      check("lw_ex_offset", ex_offset, 32'hFFFF_FFFC);

      // SW imm=0000011_00101, pops the LW
      step(1, mk(7'd3, 5'd7, 5'd0, 3'b001, 5'd5, 7'h0B), 32'h2000, 4'd2, 1, 0, 0, 0);
      check("sw_ex_offset", ex_offset, 32'd3);
      check("sw_ex_shift", ex_shift, 5'd5);

      // Unsupported funct3
      step(1, mk(7'd0, 5'd1, 5'd1, 3'b111, 5'd1, 7'h0B), 32'h0, 4'd3, 1, 0, 0, 0);
      check("f3_111_accept", s_accept, 1'b0);
      check("f3_111_ready", s_ready, 1'b1);
      check("f3_111_no_push", ex_valid, 1'b0);
      idle(1, 1, 5'd3);

      // RAW hazard: DOTP writes x2, following DOTP reads x2
      step(1, mk(7'd0, 5'd1, 5'd0, 3'b010, 5'd2, 7'h0B), 32'h0, 4'd4, 1, 0, 0, 0);
      step(1, mk(7'd0, 5'd1, 5'd2, 3'b010, 5'd8, 7'h0B), 32'h0, 4'd5, 1, 0, 0, 0);
      check("raw_stall_0", s_ready, 1'b0);
      step(1, mk(7'd0, 5'd1, 5'd2, 3'b010, 5'd8, 7'h0B), 32'h0, 4'd5, 1, 0, 0, 0);
      check("raw_stall_1", s_ready, 1'b0);
      step(1, mk(7'd0, 5'd1, 5'd2, 3'b010, 5'd8, 7'h0B), 32'h0, 4'd5, 1, 1, 5'd2, 0);
      check("raw_stall_wb_cycle", s_ready, 1'b0);
      step(1, mk(7'd0, 5'd1, 5'd2, 3'b010, 5'd8, 7'h0B), 32'h0, 4'd5, 1, 0, 0, 0);
      check("raw_released", s_ready, 1'b1);
      idle(1, 1, 5'd8);

      // FIFO full with EX stalled
      step(1, mk(7'd0, 5'd4, 5'd0, 3'b000, 5'd4, 7'h0B), 32'h10, 4'd6, 0, 0, 0, 0);
      step(1, mk(7'd0, 5'd8, 5'd0, 3'b000, 5'd5, 7'h0B), 32'h20, 4'd7, 0, 0, 0, 0);
      step(1, mk(7'd0, 5'd12, 5'd0, 3'b000, 5'd6, 7'h0B), 32'h30, 4'd8, 0, 0, 0, 0);
      check("full_stall", s_ready, 1'b0);
      step(1, mk(7'd0, 5'd12, 5'd0, 3'b000, 5'd6, 7'h0B), 32'h30, 4'd8, 1, 0, 0, 0);
      check("full_pop_no_push", s_ready, 1'b0);
      step(1, mk(7'd0, 5'd12, 5'd0, 3'b000, 5'd6, 7'h0B), 32'h30, 4'd8, 0, 0, 0, 0);
      check("full_freed", s_ready, 1'b1);
      check("order_head_id", ex_id, 4'd7);
      idle(1, 1, 5'd4); idle(1, 1, 5'd5); idle(1, 1, 5'd6);

      // Second instance: no DOTPZ, 16 registers
      step(1, mk(7'd0, 5'd1, 5'd0, 3'b011, 5'd9, 7'h0B), 32'h0, 4'd9, 1, 0, 0, 0);
      check("dotpz_en_accept", s_accept, 1'b1);
      check("dotpz_dis_accept", s2_accept, 1'b0);
      step(1, mk(7'd0, 5'd0, 5'd0, 3'b000, 5'd20, 7'h0B), 32'h0, 4'd10, 1, 0, 0, 0);
      check("rd20_nregs32_accept", s_accept, 1'b1);
      check("rd20_nregs16_accept", s2_accept, 1'b0);
      idle(1, 1, 5'd9); idle(1, 1, 5'd20);

      // Flush with two queued entries and busy bits set
      step(1, mk(7'd0, 5'd0, 5'd0, 3'b000, 5'd10, 7'h0B), 32'h40, 4'd11, 0, 0, 0, 0);
      step(1, mk(7'd0, 5'd0, 5'd0, 3'b000, 5'd11, 7'h0B), 32'h50, 4'd12, 0, 0, 0, 0);
      step(0, 32'd0, 32'd0, 4'd0, 0, 0, 0, 1);
      check("clear_ex_valid", ex_valid, 1'b0);
      step(1, mk(7'd0, 5'd11, 5'd10, 3'b010, 5'd12, 7'h0B), 32'h0, 4'd13, 1, 0, 0, 0);
      check("clear_no_hazard", s_ready, 1'b1);
      idle(1, 1, 5'd12);

      // Random phase
      for (int n = 0; n < 400; n++) begin
         logic [6:0]  opc;
         logic [31:0] ins;
         opc = ($urandom_range(0, 7) == 0) ? 7'h33 : 7'h0B;
         ins = mk(7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), opc);
         step($urandom_range(0, 3) != 0, ins, $urandom, 4'($urandom), $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), $urandom_range(0, 39) == 0);
      end

      // Asynchronous reset in the middle of a cycle
      issue_valid = 1; issue_instr = mk(7'd0, 5'd0, 5'd0, 3'b000, 5'd1, 7'h0B); ex_ready = 0;
      clear = 0; wb_valid = 0;
      @(posedge clk);
      @(posedge clk);
      issue_valid = 0;
      #3;
      rst = 1;
      #1;
      check("async_rst_ex_valid", ex_valid, 1'b0);
      check("async_rst_ex_fields", {ex_op, ex_base, ex_offset, ex_id}, '0);
      check("async_rst_ctrl", ctrl_issue, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
